// File: rtl/bus_decoder.sv
// bus_decoder: 68000-style address decoder and bus-cycle controller.
//
// Decodes the CPU address into one of NUM_CS chip-select regions, inserts a
// per-region number of wait states, optionally waits for a per-region external
// ready, optionally holds the cycle for a single-step request, then returns
// DTACK to the CPU. All outputs are registered.
//
// Optional feature: define BUS_DECODER_TIMEOUT_EN to add an 8-bit bus-cycle
// watchdog that raises BERR_OUT after TIMEOUT cycles in WAIT/EXTRDY. Without
// the macro there is no ERR state and BERR_OUT is tied low.
//
// Ports:
//   MCLK_IN      system clock, rising edge
//   RESET_n_IN   asynchronous active-low reset
//   AS_IN        address strobe (active high)
//   WR_IN        write (1) / read (0)
//   UDS_IN       upper data strobe
//   LDS_IN       lower data strobe
//   ADDR_IN      24-bit CPU address
//   READY_IN     per-region external ready
//   STEPEN_IN    single-step enable
//   STEP_IN      single-step request
//   CS_OUT       one-hot chip selects
//   OE_OUT       read output enable
//   WE_OUT       {upper, lower} write enables
//   DTACK_OUT    data transfer acknowledge
//   BERR_OUT     bus error
`timescale 1ns/1ps

module bus_decoder #(
    parameter int unsigned               NUM_CS      = 4,
    parameter logic [24*NUM_CS-1:0]      REGION_BASE = {24'h300000, 24'h200000,
                                                        24'h100000, 24'h000000},
    parameter logic [24*NUM_CS-1:0]      REGION_MASK = {4{24'hF00000}},
    parameter logic [4*NUM_CS-1:0]       REGION_WAIT = 16'h3210,
    parameter logic [NUM_CS-1:0]         REGION_EXT  = 4'b1000,
    parameter int unsigned               TIMEOUT     = 255
) (
    input  logic              MCLK_IN,
    input  logic              RESET_n_IN,
    input  logic              AS_IN,
    input  logic              WR_IN,
    input  logic              UDS_IN,
    input  logic              LDS_IN,
    input  logic [23:0]       ADDR_IN,
    input  logic [NUM_CS-1:0] READY_IN,
    input  logic              STEPEN_IN,
    input  logic              STEP_IN,
    output logic [NUM_CS-1:0] CS_OUT,
    output logic              OE_OUT,
    output logic [1:0]        WE_OUT,
    output logic              DTACK_OUT,
    output logic              BERR_OUT
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StExtRdy,
        StStepHold,
        StAck
`ifdef BUS_DECODER_TIMEOUT_EN
        , StErr
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_CS-1:0] cs_q, cs_d;
    logic              oe_q, oe_d;
    logic [1:0]        we_q, we_d;
    logic              dtack_q, dtack_d;
    logic              wr_q, wr_d;
    logic              ext_q, ext_d;
    logic [3:0]        wait_q, wait_d;
    logic              step_q;
    logic              step_pend_q, step_pend_d;

    // Address decode; iterate downwards so the lowest matching index wins.
    // An unmapped address behaves like an external-ready region that is
    // never ready, since no CS bit is set to pick a READY_IN line.
    logic [NUM_CS-1:0] dec_cs;
    logic [3:0]        dec_wait;
    logic              dec_ext;

    always_comb begin
        dec_cs   = '0;
        dec_wait = 4'd0;
        dec_ext  = 1'b1;
        for (int i = int'(NUM_CS) - 1; i >= 0; i--) begin
            if ((ADDR_IN & REGION_MASK[24*i +: 24]) ==
                (REGION_BASE[24*i +: 24] & REGION_MASK[24*i +: 24])) begin
                dec_cs    = '0;
                dec_cs[i] = 1'b1;
                dec_wait  = REGION_WAIT[4*i +: 4];
                dec_ext   = REGION_EXT[i];
            end
        end
    end

`ifdef BUS_DECODER_TIMEOUT_EN
    localparam logic [7:0] TmoLimit = 8'(TIMEOUT);
    logic [7:0] tmo_q, tmo_d;
    logic       berr_q, berr_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        oe_d        = oe_q;
        we_d        = we_q;
        dtack_d     = dtack_q;
        wr_d        = wr_q;
        ext_d       = ext_q;
        wait_d      = wait_q;
        // Step edges count only while the cycle is parked in STEPHOLD.
        step_pend_d = (state_q == StStepHold) && STEP_IN && !step_q;
`ifdef BUS_DECODER_TIMEOUT_EN
        tmo_d       = tmo_q;
        berr_d      = berr_q;
`endif

        // 68000 data strobes lag AS, so write enables follow them every edge.
        if (state_q != StIdle) begin
            we_d = wr_q ? {UDS_IN, LDS_IN} : 2'b00;
        end

        case (state_q)
            StIdle: begin
                if (AS_IN) begin
                    state_d = StWait;
                    cs_d    = dec_cs;
                    oe_d    = !WR_IN;
                    we_d    = WR_IN ? {UDS_IN, LDS_IN} : 2'b00;
                    wr_d    = WR_IN;
                    ext_d   = dec_ext;
                    wait_d  = dec_wait;
`ifdef BUS_DECODER_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end
            end
            StWait: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (ext_q) begin
                    state_d = StExtRdy;
                end else if (STEPEN_IN) begin
                    state_d = StStepHold;
                end else begin
                    state_d = StAck;
                    dtack_d = 1'b1;
                end
            end
            StExtRdy: begin
                if (|(READY_IN & cs_q)) begin
                    if (STEPEN_IN) begin
                        state_d = StStepHold;
                    end else begin
                        state_d = StAck;
                        dtack_d = 1'b1;
                    end
                end
            end
            StStepHold: begin
                if (step_pend_q) begin
                    state_d = StAck;
                    dtack_d = 1'b1;
                end
            end
            default: ;
        endcase

`ifdef BUS_DECODER_TIMEOUT_EN
        if ((state_q == StWait) || (state_q == StExtRdy)) begin
            if (tmo_q == TmoLimit) begin
                state_d = StErr;
                dtack_d = 1'b0;
                berr_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end
`endif

        // AS dropping ends the cycle from any active state, normal or aborted.
        if ((state_q != StIdle) && !AS_IN) begin
            state_d = StIdle;
            cs_d    = '0;
            oe_d    = 1'b0;
            we_d    = 2'b00;
            dtack_d = 1'b0;
`ifdef BUS_DECODER_TIMEOUT_EN
            berr_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
        if (!RESET_n_IN) begin
            state_q     <= StIdle;
            cs_q        <= '0;
            oe_q        <= 1'b0;
            we_q        <= 2'b00;
            dtack_q     <= 1'b0;
            wr_q        <= 1'b0;
            ext_q       <= 1'b0;
            wait_q      <= 4'd0;
            step_q      <= 1'b0;
            step_pend_q <= 1'b0;
`ifdef BUS_DECODER_TIMEOUT_EN
            tmo_q       <= 8'd0;
            berr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            dtack_q     <= dtack_d;
            wr_q        <= wr_d;
            ext_q       <= ext_d;
            wait_q      <= wait_d;
            step_q      <= STEP_IN;
            step_pend_q <= step_pend_d;
`ifdef BUS_DECODER_TIMEOUT_EN
            tmo_q       <= tmo_d;
            berr_q      <= berr_d;
`endif
        end
    end

    assign CS_OUT    = cs_q;
    assign OE_OUT    = oe_q;
    assign WE_OUT    = we_q;
    assign DTACK_OUT = dtack_q;
`ifdef BUS_DECODER_TIMEOUT_EN
    assign BERR_OUT  = berr_q;
`else
    assign BERR_OUT  = 1'b0;
`endif

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 Parameter NUM_CS, 4, number of chip-select regions (1..8).
REQ-002 Parameter REGION_BASE, {24'h300000,24'h200000,24'h100000,24'h000000}, packed region base; region i at [24*i+:24].
REQ-003 Parameter REGION_MASK, {4{24'hF00000}}, packed compare mask; region i matches when (ADDR_IN & mask_i) == (base_i & mask_i).
REQ-004 Parameter REGION_WAIT, 16'h3210, packed 4-bit wait-state count; region i at [4*i+:4].
REQ-005 Parameter REGION_EXT, 4'b1000, bit i set: region i also waits for READY_IN[i].
REQ-006 Parameter TIMEOUT, 255, bus-error timeout in MCLK cycles (8-bit counter).
REQ-007 MCLK_IN  in  1  system clock; all logic on rising edge.
REQ-008 RESET_n_IN  in  1  asynchronous, active-low reset.
REQ-009 AS_IN, WR_IN, UDS_IN, LDS_IN  in  1 each  active-high 68000 strobes, synchronous to MCLK_IN.
REQ-010 ADDR_IN  in  24  CPU address, valid while AS_IN high.
REQ-011 READY_IN  in  NUM_CS  per-region external ready, active high.
REQ-012 STEPEN_IN, STEP_IN  in  1 each  single-step enable, step request (active high).
REQ-013 CS_OUT  out  NUM_CS  one-hot chip selects, active high.
REQ-014 OE_OUT  out  1  read output enable; WE_OUT  out  2  {upper,lower} write enables.
REQ-015 DTACK_OUT, BERR_OUT  out  1 each  active high to CPU.

Function
REQ-016 States IDLE, WAIT, EXTRDY, STEPHOLD, ACK, ERR; all outputs registered.
REQ-017 IDLE: edge sampling AS_IN high registers decode; lowest-index matching region wins; CS_OUT, OE_OUT (=~WR_IN), WE_OUT (={UDS_IN,LDS_IN} if WR_IN) valid after that edge (E0); wait counter loads REGION_WAIT[i]; state -> WAIT.
REQ-018 WAIT: counter decrements per edge; at zero -> EXTRDY if REGION_EXT[i], else STEPHOLD if STEPEN_IN, else ACK; wait 0 gives DTACK_OUT high after E1, wait n after E(1+n).
REQ-019 EXTRDY: hold until READY_IN[i] sampled high, then -> STEPHOLD/ACK per STEPEN_IN.
REQ-020 STEPHOLD: -> ACK on edge after registered rising edge of STEP_IN; one step releases exactly one bus cycle; STEP edges outside STEPHOLD discarded.
REQ-021 ACK/ERR: hold DTACK_OUT (ACK) or BERR_OUT (ERR), CS_OUT, OE_OUT, WE_OUT until AS_IN sampled low; then all deassert on that edge, -> IDLE.
REQ-022 AS_IN sampled low in any non-IDLE state aborts: outputs cleared, -> IDLE, no DTACK_OUT/BERR_OUT.
REQ-023 WE_OUT tracks UDS_IN/LDS_IN each edge while selected (68000 write strobes lag AS).
REQ-024 DTACK_OUT and BERR_OUT never simultaneously high; CS_OUT at most one bit set.
REQ-025 Unmapped address: CS_OUT stays 0; state WAIT with count 0 then EXTRDY-equivalent hold (never ready).

Reset
REQ-026 RESET_n_IN low: immediately state IDLE, CS_OUT=0, OE_OUT=0, WE_OUT=0, DTACK_OUT=0, BERR_OUT=0, counters and STEP edge register cleared, including mid-cycle.
REQ-027 First AS_IN decode occurs on first edge after RESET_n_IN release with AS_IN high.

Configuration
REQ-028 Macro BUS_DECODER_TIMEOUT_EN defined: cycle counter clears at E0, increments in WAIT/EXTRDY; reaching TIMEOUT -> ERR (BERR_OUT high next edge); frozen in STEPHOLD.
REQ-029 Macro undefined: no counter, no ERR state, BERR_OUT tied 0; unmapped or never-ready cycles hang until AS_IN drops or reset.

Verification
REQ-030 Read 0x000010, WR_IN=0 -> CS_OUT=4'b0001, OE_OUT=1 after E0, DTACK_OUT=1 after E1; AS_IN low -> all 0 next edge.
REQ-031 Write 0x200000, UDS=LDS=1 -> CS_OUT=4'b0100, WE_OUT=2'b11, DTACK_OUT after E3.
REQ-032 Read 0x300000, READY_IN[3] raised at E10 -> DTACK_OUT after E11, not before.
REQ-033 STEPEN_IN=1, read 0x100000 -> STEPHOLD after E2, DTACK_OUT 0 for 50 cycles; STEP_IN pulse -> DTACK_OUT within 2 edges.
REQ-034 With TIMEOUT_EN, read 0x800000 -> CS_OUT=0, BERR_OUT=1 after E256; without macro, BERR_OUT stays 0.
REQ-035 RESET_n_IN low during WAIT of region 2 -> all outputs 0 asynchronously; next access decodes normally.
